sprite_blitter: RTL

//  Writer side of the sprite path. Copies one rectangular sprite from a sprite
//  ROM (4-bit palette indices) into the frame-buffer RAM that the display

---
 rtl/blit_pkg.sv | 30 +++
 rtl/sprite_blitter_if.sv | 42 ++++
 rtl/blit_addr_gen.sv | 86 ++++++++
 rtl/sprite_blitter.sv | 108 ++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
//==============================================================================
// Module : blit_pkg
// Brief  : Shared types and default geometry for the sprite blitter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package blit_pkg;

    localparam int unsigned c_FB_W       = 320;
    localparam int unsigned c_FB_H       = 240;
    localparam int unsigned c_FB_AW      = 17;
    localparam int unsigned c_TRANSP_IDX = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

    typedef struct packed {
        logic               valid;
        logic               visible;
        logic [c_FB_AW-1:0] fb_addr;
    } blit_s1_t;

endpackage

`default_nettype wire

// File: rtl/sprite_blitter_if.sv
//==============================================================================
// Module : sprite_blitter_if
// Brief  : Command, sprite ROM and frame-buffer write signals of the blitter.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface sprite_blitter_if #(
    parameter int SPR_AW = 12,
    parameter int FB_AW  = 17,
    parameter int IDX_W  = 4
);
    logic              start;
    logic [SPR_AW-1:0] spr_base;
    logic [5:0]        spr_w;
    logic [6:0]        spr_h;
    logic [9:0]        dst_x;
    logic [9:0]        dst_y;
    logic              flip_h;
    logic              busy;
    logic              done;
    logic [SPR_AW-1:0] rom_addr;
    logic [IDX_W-1:0]  rom_q;
    logic              fb_we;
    logic [FB_AW-1:0]  fb_addr;
    logic [IDX_W-1:0]  fb_wdata;
    logic              fb_ready;

    // Game logic, sprite ROM and frame-buffer arbiter side
    modport master (
        output start, spr_base, spr_w, spr_h, dst_x, dst_y, flip_h, rom_q, fb_ready,
        input  busy, done, rom_addr, fb_we, fb_addr, fb_wdata
    );

    modport slave (
        input  start, spr_base, spr_w, spr_h, dst_x, dst_y, flip_h, rom_q, fb_ready,
        output busy, done, rom_addr, fb_we, fb_addr, fb_wdata
    );

endinterface

`default_nettype wire

// File: rtl/blit_addr_gen.sv
//==============================================================================
// Module : blit_addr_gen
// Brief  : Sprite pixel walker: counters, mirroring, ROM/FB addresses, clipping.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module blit_addr_gen #(
    parameter int FB_W   = 320,
    parameter int FB_H   = 240,
    parameter int FB_AW  = 17,
    parameter int SPR_AW = 12
) (
    input  wire logic              vga_clk,
    input  wire logic              reset_n,
    input  wire logic              i_load,
    input  wire logic              i_advance,
    input  wire logic [SPR_AW-1:0] i_spr_base,
    input  wire logic [5:0]        i_spr_w,
    input  wire logic [6:0]        i_spr_h,
    input  wire logic [9:0]        i_dst_x,
    input  wire logic [9:0]        i_dst_y,
    input  wire logic              i_flip_h,
    output logic      [SPR_AW-1:0] o_rom_addr,
    output logic      [FB_AW-1:0]  o_fb_addr,
    output logic                   o_clip,
    output logic                   o_last_pixel
);

    logic [SPR_AW-1:0] r_base;
    logic [5:0]        r_w;
    logic [6:0]        r_h;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic              r_flip;
    logic [5:0]        r_sx;
    logic [6:0]        r_sy;

    logic [5:0]        w_col;
    logic [10:0]       w_px;
    logic [10:0]       w_py;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_base <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_flip <= 1'b0;
            r_sx   <= '0;
            r_sy   <= '0;
        end else if (i_load) begin
            r_base <= i_spr_base;
            r_w    <= i_spr_w;
            r_h    <= i_spr_h;
            r_x    <= i_dst_x;
            r_y    <= i_dst_y;
            r_flip <= i_flip_h;
            r_sx   <= '0;
            r_sy   <= '0;
        end else if (i_advance) begin
            if (r_sx == r_w - 6'd1) begin
                r_sx <= '0;
                r_sy <= r_sy + 7'd1;
            end else begin
                r_sx <= r_sx + 6'd1;
            end
        end
    end

    assign w_col = r_flip ? (r_w - 6'd1 - r_sx) : r_sx;

    // Modular arithmetic: the low SPR_AW bits match a wider sum truncated, so ROM wrap is preserved
    assign o_rom_addr = r_base + SPR_AW'(r_sy) * SPR_AW'(r_w) + SPR_AW'(w_col);

    assign w_px = 11'(r_x) + 11'(r_sx);
    assign w_py = 11'(r_y) + 11'(r_sy);

    assign o_fb_addr    = FB_AW'(w_py) * FB_AW'(FB_W) + FB_AW'(w_px);
    assign o_clip       = !((w_px < 11'(FB_W)) && (w_py < 11'(FB_H)));
    assign o_last_pixel = (r_sx == r_w - 6'd1) && (r_sy == r_h - 7'd1);

endmodule

`default_nettype wire

// File: rtl/sprite_blitter.sv
//==============================================================================
// Module : sprite_blitter
// Brief  : Copies a sprite from ROM into the frame buffer with clip/flip/skip.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module sprite_blitter
    import blit_pkg::*;
#(
    parameter int FB_W       = c_FB_W,
    parameter int FB_H       = c_FB_H,
    parameter int FB_AW      = c_FB_AW,
    parameter int SPR_AW     = 12,
    parameter int IDX_W      = 4,
    parameter int TRANSP_IDX = c_TRANSP_IDX
) (
    input  wire logic        vga_clk,
    input  wire logic        reset_n,
    sprite_blitter_if.slave  bus
);

    blit_state_t       r_state;
    blit_state_t       w_state_nxt;
    blit_s1_t          r_s1;
    logic [SPR_AW-1:0] r_s1_rom_addr;

    logic              w_load;
    logic              w_zero_size;
    logic              w_fb_we;
    logic              w_stall;
    logic              w_issue;
    logic [SPR_AW-1:0] w_gen_rom_addr;
    logic [FB_AW-1:0]  w_gen_fb_addr;
    logic              w_gen_clip;
    logic              w_gen_last;

    assign w_load      = (r_state == IDLE) && bus.start;
    assign w_zero_size = (bus.spr_w == 6'd0) || (bus.spr_h == 7'd0);
    assign w_fb_we     = r_s1.valid && r_s1.visible && (bus.rom_q != IDX_W'(TRANSP_IDX));
    assign w_stall     = w_fb_we && !bus.fb_ready;
    assign w_issue     = (r_state == RUN) && !w_stall;

    blit_addr_gen #(
        .FB_W   (FB_W),
        .FB_H   (FB_H),
        .FB_AW  (FB_AW),
        .SPR_AW (SPR_AW)
    ) u_addr_gen (
        .vga_clk      (vga_clk),
        .reset_n      (reset_n),
        .i_load       (w_load),
        .i_advance    (w_issue),
        .i_spr_base   (bus.spr_base),
        .i_spr_w      (bus.spr_w),
        .i_spr_h      (bus.spr_h),
        .i_dst_x      (bus.dst_x),
        .i_dst_y      (bus.dst_y),
        .i_flip_h     (bus.flip_h),
        .o_rom_addr   (w_gen_rom_addr),
        .o_fb_addr    (w_gen_fb_addr),
        .o_clip       (w_gen_clip),
        .o_last_pixel (w_gen_last)
    );

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = w_zero_size ? DONE : RUN;
            RUN:     if (w_issue && w_gen_last) w_state_nxt = DRAIN;
            DRAIN:   if (!r_s1.valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Stage 1 lines up with the ROM data: it is captured on the same edge the ROM samples rom_addr
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1          <= '0;
            r_s1_rom_addr <= '0;
        end else if (!w_stall) begin
            r_s1.valid    <= w_issue;
            r_s1.visible  <= !w_gen_clip;
            r_s1.fb_addr  <= c_FB_AW'(w_gen_fb_addr);
            r_s1_rom_addr <= w_gen_rom_addr;
        end
    end

    // While stalled, re-present the stalled pixel's address so rom_q keeps its data
    assign bus.rom_addr = w_stall ? r_s1_rom_addr : w_gen_rom_addr;
    assign bus.fb_we    = w_fb_we;
    assign bus.fb_addr  = r_s1.fb_addr[FB_AW-1:0];
    assign bus.fb_wdata = w_fb_we ? bus.rom_q : '0;
    assign bus.busy     = (r_state != IDLE);
    assign bus.done     = (r_state == DONE);

endmodule

`default_nettype wire
